baud_tick_gen_frac: RTL and testbench

BAUD_TICK_GEN_FRAC -- requirements
Module: baud_tick_gen_frac

---
 rtl/baud_pkg.sv | 13 +
 rtl/baud_frac_div.sv | 98 +++++++++
 rtl/baud_tick_gen_frac.sv | 75 +++++++
 tb/tb_baud_tick_gen_frac.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants and the reset-default divisor helper for the baud tick generator.
package baud_pkg;

  // Divisors below this are clamped, so a period is never shorter than 2 clocks.
  localparam int MIN_DIV  = 2;
  localparam int DEF_BAUD = 115200;

  // Integer clocks per oversample tick at the default baud rate.
  function automatic int default_div(input int clk_freq, input int osr);
    return clk_freq / (DEF_BAUD * osr);
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional period divisor: period counter, fractional accumulator and a
// shadow/active divisor pair. Emits a registered os_tick at the end of every
// period, plus the unregistered tick_due so the parent can register
// coincident derived ticks.
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick_due,
  output logic              os_tick
);

  localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(default_div(CLK_FREQ, OSR));
  localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(MIN_DIV);
  localparam logic [DIV_W:0]   ONE     = (DIV_W+1)'(1);

  logic              run;
  logic [DIV_W:0]    cnt;
  logic [DIV_W:0]    len;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   sum;
  logic [DIV_W-1:0]  shd_int, act_int, eff_int;
  logic [FRAC_W-1:0] shd_frac, act_frac;
  logic              period_end;

  // Length of the current period: clamped integer part plus fractional carry.
  always_comb begin
    eff_int    = (act_int < MIN_INT) ? MIN_INT : act_int;
    sum        = {1'b0, frac_acc} + {1'b0, act_frac};
    len        = {1'b0, eff_int} + {{DIV_W{1'b0}}, sum[FRAC_W]};
    period_end = enable && run && (cnt == len - ONE);
    tick_due   = period_end && !restart;
  end

  // Shadow captures on load; active follows at a period end or while idle.
  // A load on the period-end edge goes straight to active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shd_int  <= DEF_INT;
      shd_frac <= '0;
      act_int  <= DEF_INT;
      act_frac <= '0;
    end else begin
      if (load) begin
        shd_int  <= div_int;
        shd_frac <= div_frac;
      end
      if (!enable || tick_due) begin
        act_int  <= load ? div_int  : shd_int;
        act_frac <= load ? div_frac : shd_frac;
      end
    end
  end

  // Period counter and fractional accumulator. The first enabled edge only
  // arms the generator, so the first tick lands one full period later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run      <= 1'b0;
      cnt      <= '0;
      frac_acc <= '0;
      os_tick  <= 1'b0;
    end else if (!enable) begin
      run      <= 1'b0;
      cnt      <= '0;
      frac_acc <= '0;
      os_tick  <= 1'b0;
    end else if (restart) begin
      run      <= 1'b1;
      cnt      <= '0;
      frac_acc <= '0;
      os_tick  <= 1'b0;
    end else if (!run) begin
      run      <= 1'b1;
      cnt      <= '0;
      os_tick  <= 1'b0;
    end else if (tick_due) begin
      cnt      <= '0;
      frac_acc <= sum[FRAC_W-1:0];
      os_tick  <= 1'b1;
    end else begin
      cnt      <= cnt + ONE;
      os_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_gen_frac.sv
// Fractional baud tick generator: oversample tick, bit-centre tick and
// bit-end tick. Define BAUD_RESYNC_EN to make resync realign the bit phase;
// otherwise resync is accepted and ignored.
module baud_tick_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  input  logic              resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int              CNT_W    = $clog2(OSR);
  localparam logic [CNT_W-1:0] MID_IDX  = CNT_W'(OSR/2 - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OSR - 1);

  logic             restart;
  logic             tick_due;
  logic [CNT_W-1:0] os_cnt;

`ifdef BAUD_RESYNC_EN
  assign restart = resync;
`else
  logic unused_resync;
  assign unused_resync = resync;
  assign restart       = 1'b0;
`endif

  baud_frac_div #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .OSR      (OSR)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .restart  (restart),
    .load     (load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .tick_due (tick_due),
    .os_tick  (os_tick)
  );

  // Oversample position and derived ticks, registered on the same edge as os_tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      os_cnt   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (!enable || restart) begin
      os_cnt   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      mid_tick <= tick_due && (os_cnt == MID_IDX);
      bit_tick <= tick_due && (os_cnt == LAST_IDX);
      if (tick_due)
        os_cnt <= (os_cnt == LAST_IDX) ? '0 : os_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Scoreboard bench for baud_tick_gen_frac: the driver pushes expected tick
// edges, a negedge monitor pops and compares whenever any tick is high.
module tb_baud_tick_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  typedef struct {
    int t;
    bit mid;
    bit bt;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              load;
  logic              resync;
  logic              os_tick, mid_tick, bit_tick;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  baud_tick_gen_frac #(
    .CLK_FREQ (50000000),
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .OSR      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .div_int  (div_int),
    .div_frac (div_frac),
    .load     (load),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (os_tick === 1'b1 || mid_tick === 1'b1 || bit_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d got os/mid/bit=%b%b%b required none",
                 cyc, os_tick, mid_tick, bit_tick);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.t != cyc || os_tick !== 1'b1 || mid_tick !== e.mid || bit_tick !== e.bt) begin
          errors++;
          $display("FAIL tick cyc=%0d got os/mid/bit=%b%b%b required cyc=%0d os/mid/bit=1%b%b",
                   cyc, os_tick, mid_tick, bit_tick, e.t, e.mid, e.bt);
        end
      end
    end
  end

  task automatic push(input int t, input bit mid, input bit bt);
    exp_t e;
    e.t = t; e.mid = mid; e.bt = bt;
    exp_q.push_back(e);
  endtask

  // n ticks of constant period after edge k; idx0 is the os position of the first one.
  task automatic push_run(input int k, input int per, input int n, input int idx0);
    for (int i = 1; i <= n; i++) begin
      int idx;
      idx = (idx0 + i - 1) % 16;
      push(k + per * i, idx == 7, idx == 15);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle_load(input int di, input int df);
    @(negedge clk);
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic start(output int k);
    @(negedge clk);
    enable = 1'b1;
    k = cyc + 1;
  endtask

  task automatic finish_phase(input string name, input int last);
    wait_until(last);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_ticks got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int k, k2, t;
    rst = 1'b0; enable = 1'b0; load = 1'b0; resync = 1'b0;
    div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    check_bit("reset_os",  os_tick,  1'b0);
    check_bit("reset_mid", mid_tick, 1'b0);
    check_bit("reset_bit", bit_tick, 1'b0);
    rst = 1'b1;

    // Reset divisor 50e6/(115200*16) = 27: tick every 27, mid on 8th, bit at 432.
    start(k);
    push_run(k, 27, 16, 0);
    finish_phase("default27", k + 432);

    // 27 + 2/16: periods 8 and 16 are 28, bit at 434.
    idle_load(27, 2);
    start(k);
    t = k;
    for (int i = 1; i <= 16; i++) begin
      t += (i == 8 || i == 16) ? 28 : 27;
      push(t, i == 8, i == 16);
    end
    finish_phase("frac", k + 434);

    // Load 54 mid-period: current period stays 27.
    idle_load(27, 0);
    start(k);
    push(k + 27, 0, 0);
    push(k + 81, 0, 0);
    push(k + 135, 0, 0);
    wait_until(k + 10);
    div_int = DIV_W'(54); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    finish_phase("load_mid", k + 135);

    // Load on the period-end edge takes effect for the next period.
    idle_load(27, 0);
    start(k);
    push(k + 27, 0, 0);
    push(k + 67, 0, 0);
    wait_until(k + 26);
    div_int = DIV_W'(40); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    finish_phase("load_edge", k + 67);

    // div_int=1 clamps to 2.
    idle_load(1, 0);
    start(k);
    push_run(k, 2, 4, 0);
    finish_phase("div1", k + 8);

    // Enable low for 5 clocks mid-bit: restart one period later at os_cnt 0.
    idle_load(27, 0);
    start(k);
    push_run(k, 27, 3, 0);
    wait_until(k + 91);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    k2 = cyc + 1;
    push_run(k2, 27, 8, 0);
    finish_phase("reenable", k2 + 216);

    // Resync sampled on the edge the 4th tick is due.
    start(k);
    push_run(k, 27, 3, 0);
    wait_until(k + 107);
`ifdef BAUD_RESYNC_EN
    push_run(k + 108, 27, 8, 0);
    t = k + 108 + 216;
`else
    push_run(k + 81, 27, 8, 3);
    t = k + 81 + 216;
`endif
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    finish_phase("resync", t);

    // Reset mid-period with load pending: no tick, divisor back to 27.
    idle_load(54, 0);
    start(k);
    wait_until(k + 20);
    rst = 1'b0; div_int = DIV_W'(5); load = 1'b1;
    @(negedge clk);
    check_bit("midrst_os",  os_tick,  1'b0);
    check_bit("midrst_mid", mid_tick, 1'b0);
    check_bit("midrst_bit", bit_tick, 1'b0);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    k2 = cyc + 1;
    push_run(k2, 27, 2, 0);
    finish_phase("midrst", k2 + 54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
